io_uart_bridge: RTL and testbench

IO_UART_BRIDGE -- requirements
Module: io_uart_bridge

---
 rtl/io_uart_bridge_if.sv | 19 +
 rtl/io_uart_bridge.sv | 218 +++++++++++++++++++++
 tb/tb_io_uart_bridge.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/io_uart_bridge_if.sv
// Core-side byte handshake bundle for io_uart_bridge: RX FIFO read port and TX byte offer.
interface io_uart_bridge_if;
  logic [7:0] io_in_data;
  logic       io_in_vld;
  logic       io_in_rdy;
  logic [7:0] io_out_data;
  logic       io_out_vld;
  logic       io_out_rdy;

  modport master (
    input  io_in_data, io_in_vld, io_out_rdy,
    output io_in_rdy, io_out_data, io_out_vld
  );

  modport slave (
    output io_in_data, io_in_vld, io_out_rdy,
    input  io_in_rdy, io_out_data, io_out_vld
  );
endinterface

// File: rtl/io_uart_bridge.sv
// 8N1 UART bridge: independent TX shifter and RX sampler feeding a small byte FIFO,
// exposed to the core through io_uart_bridge_if.
module io_uart_bridge #(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned FIFO_AW     = 2
) (
  input  logic             clk,
  input  logic             rstn,
  io_uart_bridge_if.slave  bus,
  input  logic             uart_rxd,
  output logic             uart_txd,
  output logic             rx_overrun,
  output logic             rx_frame_err
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [FIFO_AW:0] PTR_ONE   = (FIFO_AW + 1)'(1);

  // ---------------- TX ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t        r_tx_state, w_tx_state_nx;
  logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nx;
  logic [2:0]       r_tx_bit, w_tx_bit_nx;
  logic [7:0]       r_tx_shift, w_tx_shift_nx;
  logic             r_txd, w_txd_nx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_bit   <= w_tx_bit_nx;
      r_tx_shift <= w_tx_shift_nx;
      r_txd      <= w_txd_nx;
    end
  end

  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = r_tx_cnt + CNT_ONE;
    w_tx_bit_nx   = r_tx_bit;
    w_tx_shift_nx = r_tx_shift;
    w_txd_nx      = r_txd;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_nx = '0;
        w_txd_nx    = 1'b1;
        if (bus.io_out_vld) begin
          w_tx_state_nx = TX_START;
          w_tx_shift_nx = bus.io_out_data;
          w_txd_nx      = 1'b0;
        end
      end
      TX_START: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_state_nx = TX_DATA;
          w_tx_cnt_nx   = '0;
          w_tx_bit_nx   = '0;
          w_txd_nx      = r_tx_shift[0];
          w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
        end
      end
      TX_DATA: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nx = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_nx = TX_STOP;
            w_txd_nx      = 1'b1;
          end else begin
            w_tx_bit_nx   = r_tx_bit + 3'd1;
            w_txd_nx      = r_tx_shift[0];
            w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
          end
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_state_nx = TX_IDLE;
          w_tx_cnt_nx   = '0;
        end
      end
      default: begin
        w_tx_state_nx = TX_IDLE;
        w_tx_cnt_nx   = '0;
        w_txd_nx      = 1'b1;
      end
    endcase
  end

  assign bus.io_out_rdy = (r_tx_state == TX_IDLE);
  assign uart_txd       = r_txd;

  // ---------------- RX ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  logic [1:0]       r_sync;
  logic             w_rxd;
  rx_state_t        r_rx_state, w_rx_state_nx;
  logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nx;
  logic [2:0]       r_rx_bit, w_rx_bit_nx;
  logic [7:0]       r_rx_shift, w_rx_shift_nx;
  logic             w_rx_push, w_ferr_set;

  assign w_rxd = r_sync[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync     <= 2'b11;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_sync     <= {r_sync[0], uart_rxd};
      r_rx_state <= w_rx_state_nx;
      r_rx_cnt   <= w_rx_cnt_nx;
      r_rx_bit   <= w_rx_bit_nx;
      r_rx_shift <= w_rx_shift_nx;
    end
  end

  // Start-bit midpoint check re-arms the counter so later samples land mid-bit.
  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_cnt_nx   = r_rx_cnt + CNT_ONE;
    w_rx_bit_nx   = r_rx_bit;
    w_rx_shift_nx = r_rx_shift;
    w_rx_push     = 1'b0;
    w_ferr_set    = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nx = '0;
        if (!w_rxd) w_rx_state_nx = RX_START;
      end
      RX_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nx   = '0;
          w_rx_bit_nx   = '0;
          w_rx_state_nx = w_rxd ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nx   = '0;
          w_rx_shift_nx = {w_rxd, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) w_rx_state_nx = RX_STOP;
          else                  w_rx_bit_nx   = r_rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nx = '0;
          if (w_rxd) begin
            w_rx_push     = 1'b1;
            w_rx_state_nx = RX_IDLE;
          end else begin
            w_ferr_set    = 1'b1;
            w_rx_state_nx = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        w_rx_cnt_nx = '0;
        if (w_rxd) w_rx_state_nx = RX_IDLE;
      end
      default: begin
        w_rx_state_nx = RX_IDLE;
        w_rx_cnt_nx   = '0;
      end
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]     r_mem [DEPTH];
  logic [FIFO_AW:0] r_wptr, r_rptr;
  logic           r_overrun, r_frame_err;
  logic           w_empty, w_full, w_pop, w_push_ok;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                     (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_pop     = bus.io_in_rdy && !w_empty;
  assign w_push_ok = w_rx_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr[FIFO_AW-1:0]] <= r_rx_shift;
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      if (w_rx_push && !w_push_ok) r_overrun <= 1'b1;
      if (w_ferr_set) r_frame_err <= 1'b1;
    end
  end

  assign bus.io_in_data = r_mem[r_rptr[FIFO_AW-1:0]];
  assign bus.io_in_vld  = !w_empty;
  assign rx_overrun     = r_overrun;
  assign rx_frame_err   = r_frame_err;

endmodule

// File: tb/tb_io_uart_bridge.sv
// Self-checking bench for io_uart_bridge: randomized TX/RX traffic against a
// queue-based model of the 8N1 line and the RX FIFO.
module tb_io_uart_bridge;
  localparam int unsigned CPB   = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic uart_rxd = 1'b1;
  logic uart_txd, rx_overrun, rx_frame_err;

  io_uart_bridge_if bus();

  io_uart_bridge #(.CLK_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus),
    .uart_rxd     (uart_rxd),
    .uart_txd     (uart_txd),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  int unsigned  n_cmp = 0;
  int unsigned  n_err = 0;
  byte unsigned mq[$];
  bit           m_ovr = 1'b0;
  bit           m_ferr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_rx(input byte unsigned b, input bit stop_ok);
    if (!stop_ok)                m_ferr = 1'b1;
    else if (mq.size() < DEPTH)  mq.push_back(b);
    else                         m_ovr = 1'b1;
  endfunction

  task automatic send_frame(input byte unsigned b, input bit stop_ok, input int unsigned hold_low);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int unsigned k = 0; k < 10; k++) begin
      uart_rxd = fr[k];
      repeat (CPB) tick();
    end
    if (!stop_ok) repeat (hold_low) tick();
    uart_rxd = 1'b1;
    model_rx(b, stop_ok);
  endtask

  task automatic check_rx_state(input string tag);
    repeat (3) tick();
    check({tag, "_vld"}, bus.io_in_vld, (mq.size() != 0));
    if (mq.size() != 0) check({tag, "_data"}, bus.io_in_data, mq[0]);
    check({tag, "_ovr"},  rx_overrun, m_ovr);
    check({tag, "_ferr"}, rx_frame_err, m_ferr);
  endtask

  task automatic pop_one(input string tag);
    bus.io_in_rdy = 1'b1;
    tick();
    bus.io_in_rdy = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
    check({tag, "_vld"}, bus.io_in_vld, (mq.size() != 0));
    if (mq.size() != 0) check({tag, "_data"}, bus.io_in_data, mq[0]);
  endtask

  task automatic tx_byte(input byte unsigned b);
    logic [9:0]  fr;
    int unsigned w;
    w = 0;
    while (!bus.io_out_rdy && w < 200) begin
      tick();
      w++;
    end
    check("tx_rdy_wait", bus.io_out_rdy, 1);
    fr = {1'b1, b, 1'b0};
    bus.io_out_data = b;
    bus.io_out_vld  = 1'b1;
    tick();
    bus.io_out_vld  = 1'b0;
    bus.io_out_data = 8'($urandom);
    check("tx_busy", bus.io_out_rdy, 0);
    for (int unsigned i = 0; i < 10 * CPB; i++) begin
      check($sformatf("tx_bit%0d_b%02h", i / CPB, b), uart_txd, fr[i / CPB]);
      if (i == 10 * CPB - 1) check("tx_rdy_late", bus.io_out_rdy, 0);
      tick();
    end
    check("tx_rdy_back", bus.io_out_rdy, 1);
    check("tx_idle_line", uart_txd, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]   fr;
    bit           found;
    byte unsigned b;
    int unsigned  bad;

    bus.io_in_rdy   = 1'b0;
    bus.io_out_vld  = 1'b0;
    bus.io_out_data = 8'h00;
    repeat (3) tick();
    check("rst_txd", uart_txd, 1);
    check("rst_out_rdy", bus.io_out_rdy, 1);
    check("rst_in_vld", bus.io_in_vld, 0);
    check("rst_in_data", bus.io_in_data, 0);
    check("rst_ovr", rx_overrun, 0);
    check("rst_ferr", rx_frame_err, 0);
    rstn = 1'b1;
    repeat (2) tick();

    // TX: directed then random
    tx_byte(8'hA5);
    repeat (3) tx_byte(8'($urandom));

    // RX latency with a directed byte
    fr = {1'b1, 8'h3C, 1'b0};
    found = 1'b0;
    for (int unsigned i = 0; i < 10 * CPB + 4; i++) begin
      uart_rxd = (i < 10 * CPB) ? fr[i / CPB] : 1'b1;
      tick();
      if (bus.io_in_vld) begin
        found = 1'b1;
        break;
      end
    end
    uart_rxd = 1'b1;
    model_rx(8'h3C, 1'b1);
    check("rx_latency", found, 1);
    check("rx_3c_data", bus.io_in_data, 8'h3C);
    pop_one("rx_3c_pop");

    // Glitch, then confirm RX still decodes
    uart_rxd = 1'b0;
    tick();
    uart_rxd = 1'b1;
    repeat (12) tick();
    check("glitch_vld", bus.io_in_vld, 0);
    check("glitch_ferr", rx_frame_err, 0);
    send_frame(8'($urandom), 1'b1, 0);
    check_rx_state("post_glitch");
    pop_one("post_glitch_pop");

    // Overrun: five frames into a four-deep FIFO
    for (int unsigned i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0);
    check_rx_state("ovr");
    for (int unsigned i = 0; i < 4; i++) pop_one($sformatf("ovr_pop%0d", i));
    check("ovr_drained", bus.io_in_vld, 0);

    // Framing error with line held low
    send_frame(8'hE7, 1'b0, 20);
    check("ferr_set", rx_frame_err, 1);
    check("ferr_nopush", bus.io_in_vld, 0);
    uart_rxd = 1'b0;
    repeat (2 * CPB * 10) tick();
    check("ferr_wait_low", bus.io_in_vld, 0);
    uart_rxd = 1'b1;
    repeat (4) tick();
    send_frame(8'h55, 1'b1, 0);
    check_rx_state("after_ferr");
    pop_one("after_ferr_pop");

    // Random RX traffic with interleaved pops
    for (int unsigned n = 0; n < 14; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 4) != 0) send_frame(b, 1'b1, 0);
      else                           send_frame(b, 1'b0, 4);
      check_rx_state($sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) pop_one($sformatf("rnd%0d_pop", n));
    end
    while (mq.size() != 0) pop_one("drain");

    // TX and RX running concurrently
    b = 8'($urandom);
    fork
      tx_byte(8'($urandom));
      send_frame(b, 1'b1, 0);
    join
    check_rx_state("concurrent");
    pop_one("concurrent_pop");

    // Reset during TX data bit 3
    bus.io_out_data = 8'h00;
    bus.io_out_vld  = 1'b1;
    tick();
    bus.io_out_vld  = 1'b0;
    repeat (4 * CPB + 1) tick();
    check("pre_rst_txd_bit3", uart_txd, 0);
    #2 rstn = 1'b0;
    #1;
    mq.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    check("mid_rst_txd", uart_txd, 1);
    check("mid_rst_rdy", bus.io_out_rdy, 1);
    check("mid_rst_vld", bus.io_in_vld, 0);
    check("mid_rst_ovr", rx_overrun, 0);
    check("mid_rst_ferr", rx_frame_err, 0);
    @(negedge clk) rstn = 1'b1;
    bad = 0;
    for (int unsigned i = 0; i < 12 * CPB; i++) begin
      tick();
      if (uart_txd !== 1'b1 || bus.io_out_rdy !== 1'b1) bad++;
    end
    check("post_rst_tx_quiet", bad, 0);

    // Reset mid-RX frame: partial byte must vanish
    uart_rxd = 1'b0;
    repeat (CPB) tick();
    uart_rxd = 1'b1;
    repeat (3 * CPB) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (12 * CPB) tick();
    check("rx_rst_partial", bus.io_in_vld, 0);
    send_frame(8'($urandom), 1'b1, 0);
    check_rx_state("rx_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
